// File: rtl/mult_arbiter_sequencer.sv
// Control sequencer for a shared shift-add multiplier serving two requesters.
// Round-robin arbitration in IDLE, one LOAD cycle, WIDTH RUN cycles, one DONE pulse.
module mult_arbiter_sequencer #(
    parameter int WIDTH             = 16,
    parameter int NBITS_FOR_COUNTER = $clog2(WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0,
    input  logic                         req1,
    input  logic                         mplr_lsb,
    output logic                         load,
    output logic                         sel,
    output logic                         add_en,
    output logic                         shift_en,
    output logic                         busy,
    output logic                         done0,
    output logic                         done1,
    output logic [NBITS_FOR_COUNTER-1:0] iter_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [NBITS_FOR_COUNTER-1:0] LAST_ITER = NBITS_FOR_COUNTER'(WIDTH - 1);

    state_t                         state_q, state_d;
    logic                           grant_q, grant_d;
    logic                           last_q, last_d;
    logic [NBITS_FOR_COUNTER-1:0]   iter_q, iter_d;
    logic                           win_s;

    // State, grant, last-served and iteration counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state, arbitration and counter update
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        iter_d  = iter_q;
        // On a tie the requester not served last wins; otherwise whoever asks
        win_s   = (req0 && req1) ? ~last_q : req1;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = LOAD;
                    grant_d = win_s;
                    last_d  = win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                iter_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (iter_q == LAST_ITER) begin
                    iter_d  = '0;
                    state_d = DONE;
                end else begin
                    iter_d  = iter_q + NBITS_FOR_COUNTER'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                iter_d  = '0;
            end
        endcase
    end

    // Output decode from state, grant and multiplier LSB; forced low while in reset
    always_comb begin
        load     = 1'b0;
        sel      = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        if (reset) begin
            busy = 1'b0;
        end else begin
            sel  = grant_q;
            busy = (state_q != IDLE);
            case (state_q)
                LOAD: load = 1'b1;
                RUN: begin
                    shift_en = 1'b1;
                    add_en   = mplr_lsb;
                end
                DONE: begin
                    done0 = ~grant_q;
                    done1 = grant_q;
                end
                default: load = 1'b0;
            endcase
        end
    end

    assign iter_count = iter_q;

endmodule

// File: tb/tb_mult_arbiter_sequencer.sv
// Directed bench for mult_arbiter_sequencer with a behavioural shift-add datapath.
module tb_mult_arbiter_sequencer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic          mplr_lsb;
    logic          load, sel, add_en, shift_en, busy, done0, done1;
    logic [3:0]    iter_count;

    logic [15:0]   a0 = 16'd0, b0 = 16'd0, a1 = 16'd0, b1 = 16'd0;
    logic [31:0]   mcand_q = 32'd0;
    logic [15:0]   mplr_q = 16'd0;
    logic [31:0]   acc_q = 32'd0;

    int checks = 0;
    int errors = 0;
    int d0_cnt = 0;
    int d1_cnt = 0;

    mult_arbiter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .mplr_lsb(mplr_lsb),
        .load(load), .sel(sel), .add_en(add_en), .shift_en(shift_en), .busy(busy),
        .done0(done0), .done1(done1), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: operand mux, shift registers and accumulator
    always @(posedge clk) begin
        if (load) begin
            mcand_q <= {16'd0, (sel ? a1 : a0)};
            mplr_q  <= sel ? b1 : b0;
            acc_q   <= 32'd0;
        end else if (shift_en) begin
            if (add_en) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
        end
    end
    assign mplr_lsb = mplr_q[0];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, load, sel, add_en, shift_en, busy, done0, done1};
    endfunction

    task automatic check_excl(input string tag);
        check_val({tag, "_excl"}, 32'(int'(load) + int'(shift_en) + int'(done0) + int'(done1) <= 1), 32'd1);
        check_val({tag, "_addimp"}, 32'(add_en & ~shift_en), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        check_val("in_reset_outs", outs(), 32'd0);
        check_val("in_reset_iter", 32'(iter_count), 32'd0);
        reset = 1'b0;
        check_val("post_reset_outs", outs(), 32'd0);
    endtask

    // Entered at the negedge of the IDLE cycle in which the request is visible;
    // returns at the negedge of the DONE cycle.
    task automatic expect_op(input string tag, input logic exp_sel, input logic [15:0] mplr_v,
                             input logic [31:0] prod, input logic drop_early, input logic drop_done);
        check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_val({tag, "_load"}, {30'd0, load, busy}, 32'd3);
        check_val({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        check_val({tag, "_load_ctl"}, {30'd0, add_en, shift_en}, 32'd0);
        check_excl({tag, "_ld"});
        if (drop_early) begin
            if (exp_sel) req1 = 1'b0;
            else         req0 = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check_val({tag, "_run_iter"}, 32'(iter_count), 32'(i));
            check_val({tag, "_run_ctl"}, {29'd0, load, shift_en, add_en}, {30'd1, mplr_v[i]});
            check_val({tag, "_run_nodone"}, {30'd0, done0, done1}, 32'd0);
            check_excl({tag, "_run"});
        end
        @(negedge clk);
        check_val({tag, "_done"}, {30'd0, done0, done1}, exp_sel ? 32'd1 : 32'd2);
        check_val({tag, "_done_iter"}, 32'(iter_count), 32'd0);
        check_val({tag, "_product"}, acc_q, prod);
        check_excl({tag, "_dn"});
        if (done0) d0_cnt++;
        if (done1) d1_cnt++;
        if (drop_done) begin
            if (exp_sel) req1 = 1'b0;
            else         req0 = 1'b0;
        end
    endtask

    initial begin
        // Single request 3 x 5
        do_reset();
        a0 = 16'h0003; b0 = 16'h0005;
        req0 = 1'b1;
        expect_op("single", 1'b0, 16'h0005, 32'h0000000F, 1'b0, 1'b1);
        @(negedge clk);
        check_val("single_after_idle", outs(), 32'd0);

        // Tie from reset: requester 0 first, requester 1 loads at cycle 20
        do_reset();
        a0 = 16'h0007; b0 = 16'h0009; a1 = 16'h1234; b1 = 16'h0010;
        req0 = 1'b1; req1 = 1'b1;
        expect_op("tie0", 1'b0, 16'h0009, 32'd63, 1'b0, 1'b1);
        @(negedge clk);
        expect_op("tie1", 1'b1, 16'h0010, 32'h00012340, 1'b0, 1'b1);

        // Round robin with both requests held
        do_reset();
        a0 = 16'hFFFF; b0 = 16'hFFFF; a1 = 16'h00FF; b1 = 16'h0101;
        d0_cnt = 0; d1_cnt = 0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k[0]) expect_op("rr1", 1'b1, 16'h0101, 32'h0000FFFF, 1'b0, 1'b0);
            else      expect_op("rr0", 1'b0, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b0);
            @(negedge clk);
        end
        check_val("rr_served0", 32'(d0_cnt), 32'd4);
        check_val("rr_served1", 32'(d1_cnt), 32'd4);
        req0 = 1'b0; req1 = 1'b0;

        // Request drop after one IDLE cycle
        do_reset();
        a1 = 16'h0011; b1 = 16'h0003;
        d1_cnt = 0;
        req1 = 1'b1;
        expect_op("drop", 1'b1, 16'h0003, 32'h00000033, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check_val("drop_idle", outs(), {31'd0, 1'b0} | {25'd0, 7'b0100000});
        end
        check_val("drop_once", 32'(d1_cnt), 32'd1);

        // Reset in RUN iteration 7, then a fresh operation
        do_reset();
        a0 = 16'h0002; b0 = 16'h00FF;
        req0 = 1'b1;
        @(negedge clk);
        check_val("mid_load", 32'(load), 32'd1);
        repeat (8) @(negedge clk);
        check_val("mid_iter7", {27'd0, shift_en, iter_count}, {27'd1, 4'd7});
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_reset_outs", outs(), 32'd0);
        check_val("mid_reset_iter", 32'(iter_count), 32'd0);
        reset = 1'b0;
        check_val("mid_release_outs", outs(), 32'd0);
        expect_op("mid_fresh", 1'b0, 16'h00FF, 32'h000001FE, 1'b0, 1'b1);

        // Zero multiplier
        do_reset();
        a0 = 16'hFFFF; b0 = 16'h0000;
        req0 = 1'b1;
        expect_op("zero", 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1);
        @(negedge clk);
        check_val("zero_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
